// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults, address-width helper and read FSM states for the register file
package rf_pkg;

    localparam int BUS_WIDTH_DEF = 16;
    localparam int NUM_REGS_DEF  = 8;

    // Index width for a power-of-two register count (at least one bit).
    function automatic int addr_w(input int num_regs);
        return (num_regs <= 2) ? 1 : $clog2(num_regs);
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } rd_state_e;

endpackage

// File: rtl/rf_read_unit_if.sv
// rtl/rf_read_unit_if.sv - write port and dual read-port handshake bundle for rf_read_unit
interface rf_read_unit_if #(
    parameter int BUS_WIDTH = rf_pkg::BUS_WIDTH_DEF,
    parameter int NUM_REGS  = rf_pkg::NUM_REGS_DEF,
    localparam int ADDR_W   = rf_pkg::addr_w(NUM_REGS)
);

    logic                 regWrite;
    logic [ADDR_W-1:0]    wr_addr;
    logic [BUS_WIDTH-1:0] in;

    logic                 rd_req_a;
    logic                 rd_req_b;
    logic [ADDR_W-1:0]    rd_addr_a;
    logic [ADDR_W-1:0]    rd_addr_b;
    logic                 rd_ready_a;
    logic                 rd_ready_b;

    logic                 rd_busy_a;
    logic                 rd_busy_b;
    logic                 out_valid_a;
    logic                 out_valid_b;
    logic [BUS_WIDTH-1:0] out_a;
    logic [BUS_WIDTH-1:0] out_b;

    modport master (
        output regWrite, wr_addr, in,
        output rd_req_a, rd_req_b, rd_addr_a, rd_addr_b, rd_ready_a, rd_ready_b,
        input  rd_busy_a, rd_busy_b, out_valid_a, out_valid_b, out_a, out_b
    );

    modport slave (
        input  regWrite, wr_addr, in,
        input  rd_req_a, rd_req_b, rd_addr_a, rd_addr_b, rd_ready_a, rd_ready_b,
        output rd_busy_a, rd_busy_b, out_valid_a, out_valid_b, out_a, out_b
    );

endinterface

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one read port: IDLE/HOLD handshake FSM with registered output data
module rf_read_port
    import rf_pkg::*;
#(
    parameter int BUS_WIDTH = BUS_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd_req_i,
    input  logic                 rd_ready_i,
    input  logic [BUS_WIDTH-1:0] rd_data_i,
    output logic                 rd_busy_o,
    output logic                 out_valid_o,
    output logic [BUS_WIDTH-1:0] out_o
);

    rd_state_e            state_q, state_d;
    logic [BUS_WIDTH-1:0] out_q, out_d;

    // Busy only while a result is held and the consumer has not taken it.
    assign rd_busy_o   = (state_q == HOLD) && !rd_ready_i;
    assign out_valid_o = (state_q == HOLD);
    assign out_o       = out_q;

    // State and output data registers; reset drops any pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    // Next state: latch on request when free, hold until consumed, chain back-to-back reads.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (rd_req_i) begin
                    out_d   = rd_data_i;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (rd_ready_i) begin
                    if (rd_req_i) begin
                        out_d = rd_data_i;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/rf_read_unit.sv
// rtl/rf_read_unit.sv - register file with two handshaked read ports; RF_BYPASS_EN forwards same-edge writes
module rf_read_unit
    import rf_pkg::*;
#(
    parameter int BUS_WIDTH = BUS_WIDTH_DEF,
    parameter int NUM_REGS  = NUM_REGS_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    rf_read_unit_if.slave  bus
);

    localparam int ADDR_W = addr_w(NUM_REGS);

    logic [BUS_WIDTH-1:0] storage_q [NUM_REGS];
    logic [BUS_WIDTH-1:0] rd_data_a;
    logic [BUS_WIDTH-1:0] rd_data_b;
    logic [ADDR_W-1:0]    wr_addr;
    logic [ADDR_W-1:0]    rd_addr_a;
    logic [ADDR_W-1:0]    rd_addr_b;

    assign wr_addr   = bus.wr_addr;
    assign rd_addr_a = bus.rd_addr_a;
    assign rd_addr_b = bus.rd_addr_b;

    // Storage: register 0 is never written so it always reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                storage_q[i] <= '0;
            end
        end else if (bus.regWrite && (wr_addr != '0)) begin
            storage_q[wr_addr] <= bus.in;
        end
    end

    // Port A read data, optionally forwarding a write landing on the same edge.
    always_comb begin
        rd_data_a = storage_q[rd_addr_a];
`ifdef RF_BYPASS_EN
        if (bus.regWrite && (wr_addr == rd_addr_a)) begin
            rd_data_a = bus.in;
        end
`endif
        if (rd_addr_a == '0) begin
            rd_data_a = '0;
        end
    end

    // Port B read data, same selection as port A.
    always_comb begin
        rd_data_b = storage_q[rd_addr_b];
`ifdef RF_BYPASS_EN
        if (bus.regWrite && (wr_addr == rd_addr_b)) begin
            rd_data_b = bus.in;
        end
`endif
        if (rd_addr_b == '0) begin
            rd_data_b = '0;
        end
    end

    rf_read_port #(.BUS_WIDTH(BUS_WIDTH)) u_port_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_req_i    (bus.rd_req_a),
        .rd_ready_i  (bus.rd_ready_a),
        .rd_data_i   (rd_data_a),
        .rd_busy_o   (bus.rd_busy_a),
        .out_valid_o (bus.out_valid_a),
        .out_o       (bus.out_a)
    );

    rf_read_port #(.BUS_WIDTH(BUS_WIDTH)) u_port_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_req_i    (bus.rd_req_b),
        .rd_ready_i  (bus.rd_ready_b),
        .rd_data_i   (rd_data_b),
        .rd_busy_o   (bus.rd_busy_b),
        .out_valid_o (bus.out_valid_b),
        .out_o       (bus.out_b)
    );

endmodule

// File: tb/tb_rf_read_unit.sv
// tb/tb_rf_read_unit.sv - scoreboard bench for rf_read_unit with directed vectors
module tb_rf_read_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [15:0] exp_a_q [$];
    logic [15:0] exp_b_q [$];

    rf_read_unit_if #(.BUS_WIDTH(16), .NUM_REGS(8)) bus ();

    rf_read_unit #(.BUS_WIDTH(16), .NUM_REGS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] addr, input logic [15:0] data);
        bus.regWrite = 1'b1;
        bus.wr_addr  = addr;
        bus.in       = data;
        tick();
        bus.regWrite = 1'b0;
    endtask

    // Monitor: every accepted output (valid with ready) is compared against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid_a && bus.rd_ready_a) begin
                checks++;
                if (exp_a_q.size() == 0) begin
                    errors++;
                    $display("FAIL port_a_unexpected: got %h expected no output", bus.out_a);
                end else begin
                    logic [15:0] e;
                    e = exp_a_q.pop_front();
                    if (bus.out_a !== e) begin
                        errors++;
                        $display("FAIL port_a_data: got %h expected %h", bus.out_a, e);
                    end
                end
            end
            if (bus.out_valid_b && bus.rd_ready_b) begin
                checks++;
                if (exp_b_q.size() == 0) begin
                    errors++;
                    $display("FAIL port_b_unexpected: got %h expected no output", bus.out_b);
                end else begin
                    logic [15:0] e;
                    e = exp_b_q.pop_front();
                    if (bus.out_b !== e) begin
                        errors++;
                        $display("FAIL port_b_data: got %h expected %h", bus.out_b, e);
                    end
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n          = 1'b0;
        bus.regWrite   = 1'b0;
        bus.wr_addr    = '0;
        bus.in         = '0;
        bus.rd_req_a   = 1'b0;
        bus.rd_req_b   = 1'b0;
        bus.rd_addr_a  = '0;
        bus.rd_addr_b  = '0;
        bus.rd_ready_a = 1'b0;
        bus.rd_ready_b = 1'b0;

        #2;
        chk("reset_valid_a", {31'b0, bus.out_valid_a}, 32'd0);
        chk("reset_valid_b", {31'b0, bus.out_valid_b}, 32'd0);
        chk("reset_out_a",   {16'b0, bus.out_a}, 32'd0);
        chk("reset_out_b",   {16'b0, bus.out_b}, 32'd0);
        chk("reset_busy_a",  {31'b0, bus.rd_busy_a}, 32'd0);
        chk("reset_busy_b",  {31'b0, bus.rd_busy_b}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Write r3 then read it on port A with one-cycle latency.
        wr(3'd3, 16'h0F0F);
        bus.rd_ready_a = 1'b1;
        bus.rd_ready_b = 1'b1;
        bus.rd_req_a   = 1'b1;
        bus.rd_addr_a  = 3'd3;
        exp_a_q.push_back(16'h0F0F);
        tick();
        bus.rd_req_a = 1'b0;
        chk("r3_valid_a", {31'b0, bus.out_valid_a}, 32'd1);
        chk("r3_out_a",   {16'b0, bus.out_a}, 32'h0F0F);
        tick();

        wr(3'd5, 16'h1234);
        wr(3'd2, 16'h0001);
        wr(3'd1, 16'h1111);
        wr(3'd7, 16'h7777);

        // Same address on both ports in one cycle.
        bus.rd_req_a  = 1'b1;
        bus.rd_req_b  = 1'b1;
        bus.rd_addr_a = 3'd3;
        bus.rd_addr_b = 3'd3;
        exp_a_q.push_back(16'h0F0F);
        exp_b_q.push_back(16'h0F0F);
        tick();
        bus.rd_req_a = 1'b0;
        bus.rd_req_b = 1'b0;
        tick();

        // Writes to r0 are ignored.
        wr(3'd0, 16'hFFFF);
        bus.rd_req_a  = 1'b1;
        bus.rd_req_b  = 1'b1;
        bus.rd_addr_a = 3'd0;
        bus.rd_addr_b = 3'd0;
        exp_a_q.push_back(16'h0000);
        exp_b_q.push_back(16'h0000);
        tick();
        bus.rd_req_a = 1'b0;
        bus.rd_req_b = 1'b0;
        tick();

        // Hold r5 while it is overwritten; a request during the hold is dropped.
        bus.rd_ready_a = 1'b0;
        bus.rd_req_a   = 1'b1;
        bus.rd_addr_a  = 3'd5;
        exp_a_q.push_back(16'h1234);
        tick();
        bus.rd_req_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.regWrite = 1'b1;
            bus.wr_addr  = 3'd5;
            bus.in       = 16'hAAAA;
            if (i == 1) begin
                bus.rd_req_a  = 1'b1;
                bus.rd_addr_a = 3'd1;
            end
            tick();
            bus.regWrite = 1'b0;
            bus.rd_req_a = 1'b0;
            chk("hold_out_a",   {16'b0, bus.out_a}, 32'h1234);
            chk("hold_busy_a",  {31'b0, bus.rd_busy_a}, 32'd1);
            chk("hold_valid_a", {31'b0, bus.out_valid_a}, 32'd1);
        end
        bus.rd_ready_a = 1'b1;
        #1;
        chk("hold_busy_released", {31'b0, bus.rd_busy_a}, 32'd0);
        tick();
        tick();
        bus.rd_req_a  = 1'b1;
        bus.rd_addr_a = 3'd5;
        exp_a_q.push_back(16'hAAAA);
        tick();
        bus.rd_req_a = 1'b0;
        tick();

        // Read latched on the same edge as a write to that register.
        bus.regWrite  = 1'b1;
        bus.wr_addr   = 3'd2;
        bus.in        = 16'h5555;
        bus.rd_req_a  = 1'b1;
        bus.rd_addr_a = 3'd2;
`ifdef RF_BYPASS_EN
        exp_a_q.push_back(16'h5555);
`else
        exp_a_q.push_back(16'h0001);
`endif
        tick();
        bus.regWrite = 1'b0;
        bus.rd_req_a = 1'b0;
        tick();

        // Back-to-back reads r1, r2, r7 with no gaps.
        bus.rd_req_a  = 1'b1;
        bus.rd_addr_a = 3'd1;
        exp_a_q.push_back(16'h1111);
        tick();
        chk("b2b_valid_1", {31'b0, bus.out_valid_a}, 32'd1);
        bus.rd_addr_a = 3'd2;
        exp_a_q.push_back(16'h5555);
        tick();
        chk("b2b_valid_2", {31'b0, bus.out_valid_a}, 32'd1);
        bus.rd_addr_a = 3'd7;
        exp_a_q.push_back(16'h7777);
        tick();
        chk("b2b_valid_3", {31'b0, bus.out_valid_a}, 32'd1);
        bus.rd_req_a = 1'b0;
        tick();
        chk("b2b_idle", {31'b0, bus.out_valid_a}, 32'd0);

        // Reset in the middle of a hold discards the pending read.
        bus.rd_ready_a = 1'b0;
        bus.rd_req_a   = 1'b1;
        bus.rd_addr_a  = 3'd7;
        tick();
        bus.rd_req_a = 1'b0;
        chk("pre_reset_valid", {31'b0, bus.out_valid_a}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_valid_a", {31'b0, bus.out_valid_a}, 32'd0);
        chk("midreset_out_a",   {16'b0, bus.out_a}, 32'd0);
        chk("midreset_busy_a",  {31'b0, bus.rd_busy_a}, 32'd0);
        bus.rd_ready_a = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_reset_no_valid", {31'b0, bus.out_valid_a}, 32'd0);
        end

        // Storage was cleared by reset.
        bus.rd_req_a  = 1'b1;
        bus.rd_addr_a = 3'd7;
        exp_a_q.push_back(16'h0000);
        tick();
        bus.rd_req_a = 1'b0;
        tick();

        for (int i = 0; i < 20; i++) begin
            if (exp_a_q.size() == 0 && exp_b_q.size() == 0) break;
            tick();
        end
        chk("drain_a", exp_a_q.size(), 32'd0);
        chk("drain_b", exp_b_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_read_unit.md
RF_READ_UNIT -- requirements
Module: rf_read_unit

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 16, register data width.
REQ-002 SHALL have parameter NUM_REGS, default 8, register count (power of two, >=2); ADDR_W = log2(NUM_REGS).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 regWrite  input  1  write enable, sampled at rising clk.
REQ-007 wr_addr  input  ADDR_W  write register index.
REQ-008 in  input  BUS_WIDTH  write data.
REQ-009 rd_req_a / rd_req_b  input  1  read request, port A / port B.
REQ-010 rd_addr_a / rd_addr_b  input  ADDR_W  read index, sampled with request.
REQ-011 rd_ready_a / rd_ready_b  input  1  consumer accepts out data.
REQ-012 rd_busy_a / rd_busy_b  output  1  port cannot accept a request this cycle.
REQ-013 out_valid_a / out_valid_b  output  1  out data valid.
REQ-014 out_a / out_b  output  BUS_WIDTH  read data, registered.

Function
REQ-015 Register 0 SHALL read as all-zero; writes to index 0 SHALL be ignored.
REQ-016 When regWrite=1 at a rising edge, storage[wr_addr] SHALL take in, visible to reads from the next edge.
REQ-017 Each read port SHALL run an FSM with states IDLE and HOLD.
REQ-018 IDLE: rd_req=1 at an edge -> out latched with storage[rd_addr], out_valid=1, go to HOLD (1-cycle latency).
REQ-019 HOLD: out and out_valid SHALL stay stable until rd_ready=1 at an edge.
REQ-020 HOLD with rd_ready=1 and rd_req=1 at the same edge: new read latched, stay in HOLD (back-to-back, one read per cycle).
REQ-021 HOLD with rd_ready=1 and rd_req=0: out_valid=0, go to IDLE; out keeps last value.
REQ-022 rd_busy SHALL be 1 in HOLD with rd_ready=0, else 0; rd_req while busy SHALL be dropped.
REQ-023 Held data SHALL NOT be updated by later writes to the same register.
REQ-024 Ports A and B SHALL be independent; identical addresses on both in one cycle SHALL return identical data.
REQ-025 NUM_REGS-1 and 0 SHALL be valid addresses; no address wrap or out-of-range case exists.

Reset
REQ-026 rst_n=0 SHALL immediately clear all storage to 0, both FSMs to IDLE, out_valid_a/b=0, out_a/b=0, rd_busy_a/b=0.
REQ-027 Reset during HOLD SHALL discard the pending read; no out_valid after release until a new rd_req.
REQ-028 First request SHALL be accepted at the first rising edge with rst_n=1.

Configuration
REQ-029 Macro RF_BYPASS_EN defined: a read latched at the same edge as a write to the same nonzero index SHALL return the new in value.
REQ-030 RF_BYPASS_EN undefined: that read SHALL return the pre-write storage value.

Structure
REQ-031 Package rf_pkg SHALL hold BUS_WIDTH/NUM_REGS defaults, ADDR_W function, and the read FSM state enum (IDLE, HOLD).
REQ-032 Per-port FSM and output register SHALL be sub-module rf_read_port, instantiated twice; storage and bypass mux stay in top.

Verification
REQ-033 Reset, write 16'h0F0F to r3, req A r3 next cycle, ready=1 -> out_a=16'h0F0F, out_valid_a=1 one cycle after req.
REQ-034 Write 16'hFFFF to r0, read r0 on both ports -> out_a=out_b=16'h0000.
REQ-035 Read r5 (=16'h1234), hold rd_ready_a=0 3 cycles while writing 16'hAAAA to r5 -> out_a stays 16'h1234, rd_busy_a=1; request issued then dropped.
REQ-036 Same-edge write 16'h5555 / read r2 (old 16'h0001) -> 16'h5555 with RF_BYPASS_EN, 16'h0001 without.
REQ-037 Back-to-back reqs r1,r2,r7 with ready=1 -> three consecutive valid outputs, no gaps.
REQ-038 Assert rst_n=0 mid-HOLD -> out_valid_a=0, out_a=0 immediately; no valid after release.
